// File: rtl/bsg_fma_aux_pkg.sv
// Shared types and constants for the FMA auxiliary-adder scheduler.
//
// Contents:
//   bsg_fma_aux_byte_width_gp    - width of every operand byte and of the result
//   bsg_fma_aux_tag_max_width_gp - widest requester tag (up to 8 requesters)
//   bsg_fma_aux_operand_s        - the four operand bytes of one request
//   bsg_fma_aux_result_s         - one buffered result: mod byte plus requester tag
//   bsg_fma_aux_tag_width()      - tag width for a given requester count
package bsg_fma_aux_pkg;

    localparam int bsg_fma_aux_byte_width_gp    = 8;
    localparam int bsg_fma_aux_tag_max_width_gp = 3;

    typedef struct packed {
        logic [bsg_fma_aux_byte_width_gp-1:0] a_l;
        logic [bsg_fma_aux_byte_width_gp-1:0] a_h;
        logic [bsg_fma_aux_byte_width_gp-1:0] b_l;
        logic [bsg_fma_aux_byte_width_gp-1:0] b_h;
    } bsg_fma_aux_operand_s;

    // The tag field is sized for the largest requester count; narrower
    // configurations use only the low bits.
    typedef struct packed {
        logic [bsg_fma_aux_byte_width_gp-1:0]    mod;
        logic [bsg_fma_aux_tag_max_width_gp-1:0] tag;
    } bsg_fma_aux_result_s;

    // max(1, clog2(els)): a 2-requester scheduler still needs a 1-bit tag.
    function automatic int bsg_fma_aux_tag_width(input int els);
        return (els <= 2) ? 1 : $clog2(els);
    endfunction

endpackage

// File: rtl/bsg_fma_aux_adder.sv
// Cross-product adder used by the FMA mantissa combine path.
//
// Computes (a_h * b_l + a_l * b_h) mod 256.
//
// Ports:
//   a_l_i, a_h_i  in  8  operand A low / high byte
//   b_l_i, b_h_i  in  8  operand B low / high byte
//   mod_o         out 8  truncated cross-product sum
module bsg_fma_aux_adder
    import bsg_fma_aux_pkg::*;
(
    input  logic [bsg_fma_aux_byte_width_gp-1:0] a_l_i,
    input  logic [bsg_fma_aux_byte_width_gp-1:0] a_h_i,
    input  logic [bsg_fma_aux_byte_width_gp-1:0] b_l_i,
    input  logic [bsg_fma_aux_byte_width_gp-1:0] b_h_i,
    output logic [bsg_fma_aux_byte_width_gp-1:0] mod_o
);

    // The low byte of a product depends only on the low bytes of its factors,
    // so evaluating everything in 8-bit context gives the mod-256 result
    // directly; carries out of bit 7 are intentionally discarded.
    assign mod_o = a_h_i * b_l_i + a_l_i * b_h_i;

endmodule

// File: rtl/bsg_fma_aux_rr_arb.sv
// Round-robin arbiter with an owned priority pointer.
//
// The winner is the first requester at or after ptr, scanning upward and
// wrapping. After a grant to index k the pointer moves to (k+1) mod els_p;
// with no grant it holds.
//
// Ports:
//   clk      in  1             clock
//   reset_n  in  1             synchronous active-low reset (ptr <= 0)
//   reqs     in  els_p         request vector
//   en       in  1             grant enable (slot available, not in reset)
//   grant    out els_p         one-hot grant, zero when en=0 or no request
//   idx      out tag_width_lp  encoded winner index (valid when v=1)
//   v        out 1             a grant is issued this cycle
module bsg_fma_aux_rr_arb
    import bsg_fma_aux_pkg::*;
#(
    parameter  int els_p        = 2,
    localparam int tag_width_lp = bsg_fma_aux_tag_width(els_p)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [els_p-1:0]        reqs,
    input  logic                    en,
    output logic [els_p-1:0]        grant,
    output logic [tag_width_lp-1:0] idx,
    output logic                    v
);

    logic [tag_width_lp-1:0] ptr_reg;
    logic [tag_width_lp-1:0] ptr_next;
    logic [els_p-1:0]        upper_mask;
    logic [els_p-1:0]        upper_reqs;
    logic [els_p-1:0]        scan_reqs;

    // upper_mask marks indices at or above the pointer. If any of those are
    // requesting, the lowest of them wins; otherwise the scan has wrapped and
    // the lowest requester overall wins.
    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_lane
            assign upper_mask[gi] = (tag_width_lp'(gi) >= ptr_reg);
            assign grant[gi]      = v & (idx == tag_width_lp'(gi));
        end
    endgenerate

    assign upper_reqs = reqs & upper_mask;
    assign scan_reqs  = (|upper_reqs) ? upper_reqs : reqs;
    assign v          = en & (|reqs);

    always_comb begin
        idx = '0;
        for (int j = els_p - 1; j >= 0; j--) begin
            if (scan_reqs[j]) begin
                idx = tag_width_lp'(j);
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (v) begin
            ptr_next = (idx == tag_width_lp'(els_p - 1)) ? '0 : idx + tag_width_lp'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/bsg_fma_aux_sched.sv
// Scheduler sharing one bsg_fma_aux_adder between els_p requesters.
//
// Each cycle at most one valid request is granted round-robin; its operand
// bytes feed the adder combinationally and the result, tagged with the
// requester index, is written into a 2-entry in-order output FIFO.
//
// Ports:
//   clk_i      in  1               clock
//   reset_n_i  in  1               synchronous active-low reset
//   v_i        in  els_p           per-requester request valid
//   a_l_i      in  els_p x 8       operand A low byte
//   a_h_i      in  els_p x 8       operand A high byte
//   b_l_i      in  els_p x 8       operand B low byte
//   b_h_i      in  els_p x 8       operand B high byte
//   yumi_o     out els_p           one-hot grant (request consumed)
//   v_o        out 1               FIFO head valid
//   mod_o      out 8               head result
//   tag_o      out tag_width_lp    head requester index
//   ready_i    in  1               downstream pops the head when v_o & ready_i
module bsg_fma_aux_sched
    import bsg_fma_aux_pkg::*;
#(
    parameter  int els_p        = 2,
    localparam int tag_width_lp = bsg_fma_aux_tag_width(els_p)
) (
    input  logic                                             clk_i,
    input  logic                                             reset_n_i,
    input  logic [els_p-1:0]                                 v_i,
    input  logic [els_p-1:0][bsg_fma_aux_byte_width_gp-1:0]  a_l_i,
    input  logic [els_p-1:0][bsg_fma_aux_byte_width_gp-1:0]  a_h_i,
    input  logic [els_p-1:0][bsg_fma_aux_byte_width_gp-1:0]  b_l_i,
    input  logic [els_p-1:0][bsg_fma_aux_byte_width_gp-1:0]  b_h_i,
    output logic [els_p-1:0]                                 yumi_o,
    output logic                                             v_o,
    output logic [bsg_fma_aux_byte_width_gp-1:0]             mod_o,
    output logic [tag_width_lp-1:0]                          tag_o,
    input  logic                                             ready_i
);

    logic                                    full;
    logic                                    grant_en;
    logic                                    push;
    logic                                    pop;
    logic [tag_width_lp-1:0]                 win_idx;
    bsg_fma_aux_operand_s                    win_op;
    logic [bsg_fma_aux_byte_width_gp-1:0]    sum_mod;

    bsg_fma_aux_result_s                     mem_reg [2];
    logic                                    rd_ptr_reg;
    logic                                    wr_ptr_reg;
    logic [1:0]                              count_reg;
    logic [1:0]                              count_next;

    // Grant eligibility looks only at the registered count, never at
    // ready_i, so a pop in this cycle cannot open a slot for this cycle's
    // grant. Gating with reset keeps yumi_o low while reset is held.
    assign full     = (count_reg == 2'd2);
    assign grant_en = reset_n_i & ~full;

    bsg_fma_aux_rr_arb #(
        .els_p (els_p)
    ) u_arb (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .reqs    (v_i),
        .en      (grant_en),
        .grant   (yumi_o),
        .idx     (win_idx),
        .v       (push)
    );

    assign win_op.a_l = a_l_i[win_idx];
    assign win_op.a_h = a_h_i[win_idx];
    assign win_op.b_l = b_l_i[win_idx];
    assign win_op.b_h = b_h_i[win_idx];

    bsg_fma_aux_adder u_adder (
        .a_l_i (win_op.a_l),
        .a_h_i (win_op.a_h),
        .b_l_i (win_op.b_l),
        .b_h_i (win_op.b_h),
        .mod_o (sum_mod)
    );

    // Output FIFO. A pop while empty cannot occur because pop requires v_o.
    assign v_o   = (count_reg != 2'd0);
    assign pop   = v_o & ready_i;
    assign mod_o = mem_reg[rd_ptr_reg].mod;
    assign tag_o = mem_reg[rd_ptr_reg].tag[tag_width_lp-1:0];

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Storage is cleared on reset so the idle head reads as mod=0, tag=0.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg].mod <= sum_mod;
                mem_reg[wr_ptr_reg].tag <= bsg_fma_aux_tag_max_width_gp'(win_idx);
                wr_ptr_reg              <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_bsg_fma_aux_sched.sv
// Testbench for bsg_fma_aux_sched: directed tables on a 2-requester and a
// 4-requester instance, then randomized traffic against a queue-style model.
module tb_bsg_fma_aux_sched;

    typedef struct {
        logic             rst_n;
        logic             ready;
        logic [3:0]       v;
        logic [3:0][7:0]  al;
        logic [3:0][7:0]  ah;
        logic [3:0][7:0]  bl;
        logic [3:0][7:0]  bh;
    } stim_t;

    typedef struct {
        logic             rst_n;
        logic [3:0]       v;
        logic             ready;
        logic [3:0][2:0]  op;
        logic [3:0]       yumi;
        logic             vo;
        logic [7:0]       mod;
        logic [2:0]       tag;
        logic             chk;
    } row_t;

    // Model: pointer plus an ordered list of pending results (index 0 = head).
    typedef struct {
        int               ptr;
        int               cnt;
        logic [1:0][7:0]  m;
        logic [1:0][2:0]  t;
    } model_t;

    logic       clk;
    stim_t      st2;
    stim_t      st4;
    logic [1:0] yumi2;
    logic       vo2;
    logic [7:0] mod2;
    logic [0:0] tag2;
    logic [3:0] yumi4;
    logic       vo4;
    logic [7:0] mod4;
    logic [1:0] tag4;

    int n_checks = 0;
    int n_errors = 0;

    row_t   tab2 [21];
    row_t   tab4 [7];
    model_t m2;
    model_t m4;

    bsg_fma_aux_sched #(.els_p(2)) dut2 (
        .clk_i     (clk),
        .reset_n_i (st2.rst_n),
        .v_i       (st2.v[1:0]),
        .a_l_i     (st2.al[1:0]),
        .a_h_i     (st2.ah[1:0]),
        .b_l_i     (st2.bl[1:0]),
        .b_h_i     (st2.bh[1:0]),
        .yumi_o    (yumi2),
        .v_o       (vo2),
        .mod_o     (mod2),
        .tag_o     (tag2),
        .ready_i   (st2.ready)
    );

    bsg_fma_aux_sched #(.els_p(4)) dut4 (
        .clk_i     (clk),
        .reset_n_i (st4.rst_n),
        .v_i       (st4.v),
        .a_l_i     (st4.al),
        .a_h_i     (st4.ah),
        .b_l_i     (st4.bl),
        .b_h_i     (st4.bh),
        .yumi_o    (yumi4),
        .v_o       (vo4),
        .mod_o     (mod4),
        .tag_o     (tag4),
        .ready_i   (st4.ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Operand sets, packed as {a_l, a_h, b_l, b_h}.
    function automatic logic [31:0] op_bytes(input logic [2:0] c);
        case (c)
            3'd1:    return {8'h34, 8'h12, 8'h56, 8'h78};
            3'd2:    return 32'hFFFF_FFFF;
            3'd3:    return {8'd1, 8'd2, 8'd3, 8'd4};
            3'd4:    return {8'd5, 8'd6, 8'd7, 8'd8};
            default: return 32'h0;
        endcase
    endfunction

    function automatic row_t mk(input logic rst_n, input logic [3:0] v, input logic ready,
                                input logic [11:0] op, input logic [3:0] yumi, input logic vo,
                                input logic [7:0] mod, input logic [2:0] tag, input logic c);
        row_t r;
        r.rst_n = rst_n; r.v = v; r.ready = ready; r.op = op;
        r.yumi = yumi; r.vo = vo; r.mod = mod; r.tag = tag; r.chk = c;
        return r;
    endfunction

    function automatic logic [7:0] ref_mod(input logic [7:0] al, input logic [7:0] ah,
                                           input logic [7:0] bl, input logic [7:0] bh);
        int s;
        s = int'(ah) * int'(bl) + int'(al) * int'(bh);
        return 8'(s % 256);
    endfunction

    function automatic int pick(input model_t m, input stim_t s, input int els);
        if (!s.rst_n || m.cnt >= 2) return -1;
        for (int i = 0; i < els; i++) begin
            int k;
            k = (m.ptr + i) % els;
            if (s.v[k]) return k;
        end
        return -1;
    endfunction

    function automatic model_t advance(input model_t m, input stim_t s, input int els);
        model_t n;
        int k;
        n = m;
        k = pick(m, s, els);
        if (!s.rst_n) begin
            n.ptr = 0;
            n.cnt = 0;
            return n;
        end
        if (n.cnt > 0 && s.ready) begin
            n.m[0] = n.m[1];
            n.t[0] = n.t[1];
            n.cnt--;
        end
        if (k >= 0) begin
            n.m[n.cnt] = ref_mod(s.al[k], s.ah[k], s.bl[k], s.bh[k]);
            n.t[n.cnt] = 3'(k);
            n.cnt++;
            n.ptr = (k + 1) % els;
        end
        return n;
    endfunction

    task automatic apply_row(input int which, input int idx, input row_t r);
        stim_t s;
        logic [3:0] y;
        logic       vo;
        logic [7:0] md;
        logic [2:0] tg;
        s.rst_n = r.rst_n;
        s.ready = r.ready;
        s.v     = r.v;
        for (int k = 0; k < 4; k++) begin
            {s.al[k], s.ah[k], s.bl[k], s.bh[k]} = op_bytes(r.op[k]);
        end
        if (which == 2) st2 = s; else st4 = s;
        @(negedge clk);
        if (which == 2) begin
            y = {2'b00, yumi2}; vo = vo2; md = mod2; tg = {2'b00, tag2};
        end else begin
            y = yumi4; vo = vo4; md = mod4; tg = {1'b0, tag4};
        end
        chk($sformatf("tab%0d[%0d] yumi_o", which, idx), 32'(y), 32'(r.yumi));
        chk($sformatf("tab%0d[%0d] v_o", which, idx), 32'(vo), 32'(r.vo));
        if (r.chk) begin
            chk($sformatf("tab%0d[%0d] mod_o", which, idx), 32'(md), 32'(r.mod));
            chk($sformatf("tab%0d[%0d] tag_o", which, idx), 32'(tg), 32'(r.tag));
        end
        $display("tab%0d row %0d: rst_n=%b v_i=%b ready=%b yumi_o=%b v_o=%b mod_o=%02h tag_o=%0d",
                 which, idx, r.rst_n, r.v, r.ready, y, vo, md, tg);
        @(posedge clk);
        #1;
    endtask

    task automatic eval(input string nm, inout model_t m, input stim_t s, input int els,
                        input logic [3:0] yumi, input logic vo, input logic [7:0] md,
                        input logic [2:0] tg, output logic [3:0] granted);
        int k;
        k = pick(m, s, els);
        granted = (k >= 0) ? 4'(1 << k) : 4'b0000;
        chk({nm, " yumi_o"}, 32'(yumi), 32'(granted));
        chk({nm, " v_o"}, 32'(vo), (m.cnt > 0) ? 32'd1 : 32'd0);
        if (m.cnt > 0) begin
            chk({nm, " mod_o"}, 32'(md), 32'(m.m[0]));
            chk({nm, " tag_o"}, 32'(tg), 32'(m.t[0]));
            if (s.ready && s.rst_n)
                $display("%s pop: tag_o=%0d mod_o=%02h", nm, tg, md);
        end
        m = advance(m, s, els);
    endtask

    task automatic gen(inout stim_t s, input logic [3:0] granted, input int els);
        s.rst_n = ($urandom_range(49) != 0);
        s.ready = ($urandom_range(3) != 0);
        for (int k = 0; k < 4; k++) begin
            if (k >= els) begin
                s.v[k] = 1'b0;
            end else if (!(s.v[k] && !granted[k] && $urandom_range(7) != 0)) begin
                // New request (or idle) only after a grant or a voluntary drop.
                s.v[k]  = 1'($urandom_range(1));
                s.al[k] = 8'($urandom);
                s.ah[k] = 8'($urandom);
                s.bl[k] = 8'($urandom);
                s.bh[k] = 8'($urandom);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] g2;
        logic [3:0] g4;

        // op fields are {op3, op2, op1, op0}; requester k uses op_bytes(op[k]).
        tab2[0]  = mk(0, 4'b0000, 1, {3'd0,3'd0,3'd2,3'd1}, 4'b00, 0, 8'h00, 3'd0, 1);
        tab2[1]  = mk(1, 4'b0001, 1, {3'd0,3'd0,3'd2,3'd1}, 4'b01, 0, 8'h00, 3'd0, 0);
        tab2[2]  = mk(1, 4'b0000, 1, {3'd0,3'd0,3'd2,3'd1}, 4'b00, 1, 8'h6C, 3'd0, 1);
        tab2[3]  = mk(1, 4'b0010, 1, {3'd0,3'd0,3'd2,3'd1}, 4'b10, 0, 8'h00, 3'd0, 0);
        tab2[4]  = mk(1, 4'b0000, 1, {3'd0,3'd0,3'd2,3'd1}, 4'b00, 1, 8'h02, 3'd1, 1);
        tab2[5]  = mk(1, 4'b0011, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b01, 0, 8'h00, 3'd0, 0);
        tab2[6]  = mk(1, 4'b0011, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b10, 1, 8'h0A, 3'd0, 1);
        tab2[7]  = mk(1, 4'b0011, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b01, 1, 8'h52, 3'd1, 1);
        tab2[8]  = mk(1, 4'b0011, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b10, 1, 8'h0A, 3'd0, 1);
        tab2[9]  = mk(1, 4'b0011, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b01, 1, 8'h52, 3'd1, 1);
        tab2[10] = mk(1, 4'b0011, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b10, 1, 8'h0A, 3'd0, 1);
        tab2[11] = mk(1, 4'b0011, 0, {3'd0,3'd0,3'd4,3'd3}, 4'b01, 1, 8'h52, 3'd1, 1);
        tab2[12] = mk(1, 4'b0011, 0, {3'd0,3'd0,3'd4,3'd3}, 4'b00, 1, 8'h52, 3'd1, 1);
        tab2[13] = mk(1, 4'b0011, 0, {3'd0,3'd0,3'd4,3'd3}, 4'b00, 1, 8'h52, 3'd1, 1);
        tab2[14] = mk(1, 4'b0011, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b00, 1, 8'h52, 3'd1, 1);
        tab2[15] = mk(1, 4'b0001, 0, {3'd0,3'd0,3'd4,3'd3}, 4'b01, 1, 8'h0A, 3'd0, 1);
        tab2[16] = mk(1, 4'b0011, 0, {3'd0,3'd0,3'd4,3'd3}, 4'b00, 1, 8'h0A, 3'd0, 1);
        tab2[17] = mk(0, 4'b0011, 0, {3'd0,3'd0,3'd4,3'd3}, 4'b00, 1, 8'h0A, 3'd0, 1);
        tab2[18] = mk(1, 4'b0011, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b01, 0, 8'h00, 3'd0, 1);
        tab2[19] = mk(1, 4'b0000, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b00, 1, 8'h0A, 3'd0, 1);
        tab2[20] = mk(1, 4'b0000, 1, {3'd0,3'd0,3'd4,3'd3}, 4'b00, 0, 8'h00, 3'd0, 0);

        tab4[0]  = mk(0, 4'b0000, 1, {3'd4,3'd3,3'd0,3'd0}, 4'b0000, 0, 8'h00, 3'd0, 1);
        tab4[1]  = mk(1, 4'b1000, 1, {3'd4,3'd3,3'd0,3'd0}, 4'b1000, 0, 8'h00, 3'd0, 0);
        tab4[2]  = mk(1, 4'b0100, 1, {3'd4,3'd3,3'd0,3'd0}, 4'b0100, 1, 8'h52, 3'd3, 1);
        tab4[3]  = mk(1, 4'b1100, 1, {3'd4,3'd3,3'd0,3'd0}, 4'b1000, 1, 8'h0A, 3'd2, 1);
        tab4[4]  = mk(1, 4'b0100, 1, {3'd4,3'd3,3'd0,3'd0}, 4'b0100, 1, 8'h52, 3'd3, 1);
        tab4[5]  = mk(1, 4'b0000, 1, {3'd4,3'd3,3'd0,3'd0}, 4'b0000, 1, 8'h0A, 3'd2, 1);
        tab4[6]  = mk(1, 4'b0000, 1, {3'd4,3'd3,3'd0,3'd0}, 4'b0000, 0, 8'h00, 3'd0, 0);

        st2 = '{default: '0};
        st4 = '{default: '0};

        for (int i = 0; i < 21; i++) apply_row(2, i, tab2[i]);
        st2.rst_n = 1'b0;
        for (int i = 0; i < 7; i++) apply_row(4, i, tab4[i]);

        // Randomized phase: both instances from a clean reset.
        st2 = '{default: '0};
        st4 = '{default: '0};
        @(posedge clk);
        #1;
        m2 = '{ptr: 0, cnt: 0, m: '0, t: '0};
        m4 = '{ptr: 0, cnt: 0, m: '0, t: '0};
        g2 = 4'b0;
        g4 = 4'b0;
        gen(st2, g2, 2);
        gen(st4, g4, 4);
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            eval("rnd2", m2, st2, 2, {2'b00, yumi2}, vo2, mod2, {2'b00, tag2}, g2);
            eval("rnd4", m4, st4, 4, yumi4, vo4, mod4, {1'b0, tag4}, g4);
            @(posedge clk);
            #1;
            gen(st2, g2, 2);
            gen(st4, g4, 4);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bsg_fma_aux_sched.md
Name: bsg_fma_aux_sched

Overview:
- Shares a single bsg_fma_aux_adder instance between els_p requesters.
- Each cycle, picks at most one valid request by round-robin and drives its four operand bytes into the adder combinationally.
- Registers the 8-bit mod result, tagged with the requester id, into a 2-entry output FIFO.
- Sits between the FMA mantissa-split stages and the final mantissa combine stage.

Parameters:
- els_p, 2: number of requesters; legal range 2..8.
- tag_width_lp, max(1, $clog2(els_p)): width of the requester id tag; derived, not overridable.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- v_i  in  els_p  per-requester request valid.
- a_l_i  in  els_p x 8  per-requester operand A low byte.
- a_h_i  in  els_p x 8  per-requester operand A high byte.
- b_l_i  in  els_p x 8  per-requester operand B low byte.
- b_h_i  in  els_p x 8  per-requester operand B high byte.
- yumi_o  out  els_p  one-hot grant; the request is consumed this cycle.
- v_o  out  1  result valid (FIFO head).
- mod_o  out  8  result: (a_h*b_l + a_l*b_h) mod 256.
- tag_o  out  tag_width_lp  index of the requester that produced mod_o.
- ready_i  in  1  downstream accepts the head when v_o & ready_i.

Behaviour:
- Interface (already decided): one clock, clk_i; reset_n_i is synchronous and active-low.
- Reset (reset_n_i=0 at a rising edge):
  - FIFO emptied; v_o=0, mod_o=0, tag_o=0.
  - Round-robin pointer = 0.
  - yumi_o=0 during and while reset is asserted.
- Reset mid-operation discards all buffered results; no result is emitted for requests granted in the reset cycle.
- Request protocol:
  - A requester holds v_i and its operands stable until yumi_o for it is seen.
  - Operands change only after yumi_o.
  - Requester may deassert v_i before a grant; that is legal and nothing is consumed.
- Grant rule:
  - Grant is possible iff the FIFO is not full, where full means 2 entries are held.
  - yumi_o must NOT depend combinationally on ready_i. A FIFO pop in the same cycle does not free a slot for that cycle's grant.
  - Among valid requesters, the winner is the first index at or after ptr, scanning upward and wrapping modulo els_p.
  - On a grant to index k, ptr <= (k+1) mod els_p. With no grant, ptr holds.
  - yumi_o is one-hot or zero, and is zero when v_i is zero.
- Datapath:
  - Winner's bytes are muxed into the adder. The adder output and winner index are written to the FIFO tail at the clock edge.
  - Latency: grant in cycle N gives v_o=1 with that result in cycle N+1 if the FIFO was empty. Otherwise the result appears in FIFO order.
- FIFO:
  - 2 entries, in order, with separate read and write pointers plus a count.
  - Simultaneous push and pop when holding 1 entry: count stays 1, head advances.
  - Push when full: cannot happen, because the grant is blocked.
  - Pop when empty: ignored.
  - mod_o and tag_o are stable while v_o=1 and ready_i=0.
- Throughput: 1 result per cycle sustained while ready_i=1.
- Arithmetic: the product sum is truncated to 8 bits and carries beyond bit 7 are dropped. This is exactly the bsg_fma_aux_adder function.

Decomposition:
- Package bsg_fma_aux_pkg:
  - typedef bsg_fma_aux_operand_s {a_l, a_h, b_l, b_h}, each 8 bits.
  - typedef bsg_fma_aux_result_s {mod, tag}.
  - Constant bsg_fma_aux_byte_width_gp = 8.
- Sub-module bsg_fma_aux_rr_arb:
  - Parameterized by els_p.
  - Inputs: reqs, en (= not full).
  - Outputs: one-hot grant, encoded index.
  - Owns ptr.
- Top module contents:
  - Instantiates bsg_fma_aux_rr_arb and the existing bsg_fma_aux_adder.
  - Holds the FIFO inline.

Test Plan:
- Single request (els_p=2): req0 with a_h=0x12, a_l=0x34, b_l=0x56, b_h=0x78, ready_i=1 -> yumi_o=2'b01 in cycle 0; cycle 1: v_o=1, mod_o=0x6C, tag_o=0.
- Truncation: req1 with all bytes 0xFF -> mod_o=0x02, tag_o=1.
- Fairness: both requesters valid continuously, ready_i=1, 6 cycles after reset -> grants 0,1,0,1,0,1; tags out in the same order at 1-cycle lag; one result per cycle.
- Backpressure: both valid, ready_i=0 -> exactly 2 grants, then yumi_o=0 with v_o=1 and head held stable. Raise ready_i for 1 cycle -> one pop, no grant that same cycle, a grant the next cycle.
- Mid-operation reset: 2 entries buffered, assert reset_n_i=0 one cycle -> next cycle v_o=0 and ptr=0. First grant after release goes to index 0 when both are valid.
- Sparse requests (els_p=4): only req2 and req3 toggle valid -> ptr wraps 3->0. A grant to 3 followed by req2 valid gives 2 next; no grant is issued to an invalid index.
